// File: rtl/ysyx_22050854_bpu_pkg.sv
// Shared branch-predictor definitions: 2-bit direction counter encodings and update rule.
// Pure definitions; no timing or flow control of its own.
package ysyx_22050854_bpu_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h8000_0000;

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST) ? ST : ctr + 2'b01;
    else       return (ctr == SNT) ? SNT : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/ysyx_22050854_btb.sv
// Direct-mapped BTB: combinational lookup by fetch PC, write at the edge from execute.
// Lookup sees pre-edge contents (no bypass); never stalls, a write is always accepted.
module ysyx_22050854_btb
  import ysyx_22050854_bpu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-3:0] rd_pc,
  output logic            rd_hit,
  output logic            rd_dir,
  output logic [XLEN-1:0] rd_target,
  input  logic            wr_en,
  input  logic [XLEN-3:0] wr_pc,
  input  logic            wr_is_branch,
  input  logic            wr_taken,
  input  logic            wr_pred_taken,
  input  logic [XLEN-1:0] wr_target
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = XLEN - 2 - IDX;

  logic [ENTRIES-1:0] valid_q;
  logic [TW-1:0]      tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX-1:0] ri, wi;
  logic [TW-1:0]  rt, wt;
  logic           wr_hit;

  // rd_pc/wr_pc are PC[XLEN-1:2]: low IDX bits index, the rest is the tag
  assign ri = rd_pc[IDX-1:0];
  assign rt = rd_pc[XLEN-3:IDX];
  assign wi = wr_pc[IDX-1:0];
  assign wt = wr_pc[XLEN-3:IDX];

  assign rd_hit    = valid_q[ri] && (tag_q[ri] == rt);
  assign rd_dir    = ctr_q[ri][1];
  assign rd_target = target_q[ri];
  assign wr_hit    = valid_q[wi] && (tag_q[wi] == wt);

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_en) begin
      if (wr_is_branch) begin
        if (wr_hit) begin
          ctr_q[wi] <= ctr_update(ctr_q[wi], wr_taken);
          if (wr_taken) target_q[wi] <= wr_target;
        end else if (wr_taken) begin
          valid_q[wi]  <= 1'b1;
          tag_q[wi]    <= wt;
          target_q[wi] <= wr_target;
          ctr_q[wi]    <= WT;
        end
      end else if (wr_pred_taken) begin
        // a non-branch was predicted taken: the slot holds a stale alias
        valid_q[wi] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ysyx_22050854_pc_predict.sv
// Fetch PC register with BTB prediction; redirects (csr > mispredict) override stall.
// next_pc/flush are combinational, pc updates every edge; stall only holds pc.
module ysyx_22050854_pc_predict
  import ysyx_22050854_bpu_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(DEFAULT_RESET_VEC),
  parameter int              BTB_ENTRIES = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            csr_redirect,
  input  logic [XLEN-1:0] csr_pc,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_branch,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            flush,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);

  logic            hit, dir, mis;
  logic [XLEN-1:0] entry_target, pc_plus4, fix_pc;

  assign pc_plus4 = pc + XLEN'(4);

  ysyx_22050854_btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clock         (clock),
    .reset         (reset),
    .rd_pc         (pc[XLEN-1:2]),
    .rd_hit        (hit),
    .rd_dir        (dir),
    .rd_target     (entry_target),
    .wr_en         (ex_valid),
    .wr_pc         (ex_pc[XLEN-1:2]),
    .wr_is_branch  (ex_is_branch),
    .wr_taken      (ex_taken),
    .wr_pred_taken (ex_pred_taken),
    .wr_target     (ex_target)
  );

  assign pred_taken  = ~reset & hit & dir;
  assign pred_target = hit ? entry_target : pc_plus4;

  assign mis = ex_valid & ((ex_is_branch & ((ex_taken != ex_pred_taken) |
                                            (ex_taken & (ex_target != ex_pred_target)))) |
                           (~ex_is_branch & ex_pred_taken));
  assign fix_pc = (ex_taken & ex_is_branch) ? ex_target : ex_pc + XLEN'(4);
  assign flush  = ~reset & (csr_redirect | mis);

  always_comb begin
    next_pc = pc_plus4;
    if (reset)             next_pc = RESET_VEC;
    else if (csr_redirect) next_pc = csr_pc;
    else if (mis)          next_pc = fix_pc;
    else if (stall)        next_pc = pc;
    else if (pred_taken)   next_pc = pred_target;
  end

  // next_pc already folds in reset, so pc needs no separate reset branch
  always_ff @(posedge clock) begin
    pc <= next_pc;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      branch_cnt  <= branch_cnt + 32'(ex_valid & ex_is_branch);
      mispred_cnt <= mispred_cnt + 32'(mis);
    end
  end

endmodule

// File: tb/tb_ysyx_22050854_pc_predict.sv
// Directed and random checks of ysyx_22050854_pc_predict against an arithmetic reference model.
module tb_ysyx_22050854_pc_predict;

  localparam logic [31:0] RV = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset, stall, csr_redirect;
  logic [31:0] csr_pc;
  logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic [31:0] pc, next_pc, pred_target, branch_cnt, mispred_cnt;
  logic        pred_taken, flush;

  always #5 clock = ~clock;

  ysyx_22050854_pc_predict dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .csr_redirect   (csr_redirect),
    .csr_pc         (csr_pc),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_is_branch   (ex_is_branch),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .pc             (pc),
    .next_pc        (next_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .flush          (flush),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  int tests = 0;
  int fails = 0;

  // reference model: BTB slot = (pc/4) mod 16, tag = pc/64, counter 0..3
  logic [31:0] m_pc = RV;
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  logic [31:0] m_bcnt = 0, m_mcnt = 0;
  bit          primed = 0;

  logic [31:0] obs_next, obs_ptgt;
  logic        obs_flush, obs_pt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_cycle();
    int          ri, wi;
    bit          hit, whit, ept, emis;
    logic [31:0] eptgt, efix, enext;
    #1;
    ri    = int'((m_pc / 4) % 16);
    hit   = m_valid[ri] && (m_tag[ri] == m_pc / 64);
    ept   = !reset && hit && (m_ctr[ri] >= 2);
    eptgt = hit ? m_tgt[ri] : m_pc + 4;
    emis  = ex_valid && (ex_is_branch ?
             ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target)) :
             ex_pred_taken);
    efix  = (ex_is_branch && ex_taken) ? ex_target : ex_pc + 4;
    if (reset)             enext = RV;
    else if (csr_redirect) enext = csr_pc;
    else if (emis)         enext = efix;
    else if (stall)        enext = m_pc;
    else if (ept)          enext = eptgt;
    else                   enext = m_pc + 4;

    obs_next = next_pc; obs_flush = flush; obs_pt = pred_taken; obs_ptgt = pred_target;
    check("next_pc", next_pc, enext);
    check("flush", 32'(flush), 32'(!reset && (csr_redirect || emis)));
    check("pred_taken", 32'(pred_taken), 32'(ept));
    if (primed) begin
      check("pc", pc, m_pc);
      check("pred_target", pred_target, eptgt);
      check("branch_cnt", branch_cnt, m_bcnt);
      check("mispred_cnt", mispred_cnt, m_mcnt);
    end

    @(posedge clock);
    if (reset) begin
      m_pc = RV;
      for (int i = 0; i < 16; i++) m_valid[i] = 0;
      m_bcnt = 0; m_mcnt = 0;
      primed = 1;
    end else begin
      m_pc = enext;
      if (ex_valid) begin
        wi   = int'((ex_pc / 4) % 16);
        whit = m_valid[wi] && (m_tag[wi] == ex_pc / 64);
        if (ex_is_branch) m_bcnt = m_bcnt + 1;
        if (emis)         m_mcnt = m_mcnt + 1;
        if (ex_is_branch) begin
          if (whit) begin
            m_ctr[wi] = ex_taken ? ((m_ctr[wi] < 3) ? m_ctr[wi] + 1 : 3)
                                 : ((m_ctr[wi] > 0) ? m_ctr[wi] - 1 : 0);
            if (ex_taken) m_tgt[wi] = ex_target;
          end else if (ex_taken) begin
            m_valid[wi] = 1; m_tag[wi] = ex_pc / 64; m_tgt[wi] = ex_target; m_ctr[wi] = 2;
          end
        end else if (ex_pred_taken) begin
          m_valid[wi] = 0;
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic idle();
    stall = 0; csr_redirect = 0; csr_pc = 0;
    ex_valid = 0; ex_pc = 0; ex_is_branch = 0; ex_taken = 0;
    ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
  endtask

  task automatic fetch_at(input logic [31:0] a);
    csr_redirect = 1; csr_pc = a;
    run_cycle();
    csr_redirect = 0;
  endtask

  task automatic resolve(input logic [31:0] p, input bit br, input bit tk, input logic [31:0] tg,
                         input bit pt, input logic [31:0] ptg);
    ex_valid = 1; ex_pc = p; ex_is_branch = br; ex_taken = tk; ex_target = tg;
    ex_pred_taken = pt; ex_pred_target = ptg;
    run_cycle();
    ex_valid = 0;
  endtask

  initial begin
    idle();
    // 1. reset then sequential fetch
    reset = 1;
    run_cycle(); run_cycle();
    reset = 0;
    check("reset_pc", pc, RV);
    check("reset_bcnt", branch_cnt, 0);
    check("reset_mcnt", mispred_cnt, 0);
    run_cycle(); check("seq_pc1", pc, 32'h8000_0004);
    run_cycle(); check("seq_pc2", pc, 32'h8000_0008);
    check("seq_flush", 32'(obs_flush), 0);

    // 2. first taken branch allocates and mispredicts
    resolve(32'h8000_0010, 1, 1, 32'h8000_0040, 0, 32'h8000_0014);
    check("alloc_flush", 32'(obs_flush), 1);
    check("alloc_next", obs_next, 32'h8000_0040);
    check("alloc_mcnt", mispred_cnt, 1);
    fetch_at(32'h8000_0010); run_cycle();
    check("hit_pt", 32'(obs_pt), 1);
    check("hit_ptgt", obs_ptgt, 32'h8000_0040);

    // 3. down to strongly not-taken, then up past saturation
    resolve(32'h8000_0010, 1, 0, 32'h8000_0040, 1, 32'h8000_0040);
    resolve(32'h8000_0010, 1, 0, 32'h8000_0040, 1, 32'h8000_0040);
    fetch_at(32'h8000_0010); run_cycle();
    check("snt_pt", 32'(obs_pt), 0);
    check("snt_next", obs_next, 32'h8000_0014);
    for (int k = 0; k < 4; k++) resolve(32'h8000_0010, 1, 1, 32'h8000_0040, 0, 32'h8000_0014);
    resolve(32'h8000_0010, 1, 0, 32'h8000_0040, 0, 32'h8000_0014);
    fetch_at(32'h8000_0010); run_cycle();
    check("sat_pt", 32'(obs_pt), 1);

    // 4. csr redirect beats mispredict and stall; BTB still updated
    stall = 1; csr_redirect = 1; csr_pc = 32'h8000_1000;
    resolve(32'h8000_0020, 1, 1, 32'h8000_0080, 0, 32'h8000_0024);
    check("csr_next", obs_next, 32'h8000_1000);
    check("csr_flush", 32'(obs_flush), 1);
    stall = 0; csr_redirect = 0;
    fetch_at(32'h8000_0020); run_cycle();
    check("csr_upd_pt", 32'(obs_pt), 1);
    check("csr_upd_ptgt", obs_ptgt, 32'h8000_0080);

    // 5. alias on index 4, then invalidation by a non-branch
    resolve(32'h8000_0050, 1, 1, 32'h8000_0100, 0, 32'h8000_0054);
    fetch_at(32'h8000_0450); run_cycle();
    check("alias_pt", 32'(obs_pt), 0);
    check("alias_ptgt", obs_ptgt, 32'h8000_0454);
    fetch_at(32'h8000_0050); run_cycle();
    check("owner_pt", 32'(obs_pt), 1);
    resolve(32'h8000_0050, 0, 0, 32'h0, 1, 32'h8000_0100);
    check("inval_flush", 32'(obs_flush), 1);
    check("inval_next", obs_next, 32'h8000_0054);
    fetch_at(32'h8000_0050); run_cycle();
    check("inval_pt", 32'(obs_pt), 0);

    // 6. reset mid-run wipes allocations; stall holds the reset PC
    resolve(32'h8000_0060, 1, 1, 32'h8000_0200, 0, 32'h8000_0064);
    resolve(32'h8000_0064, 1, 1, 32'h8000_0300, 0, 32'h8000_0068);
    resolve(32'h8000_0068, 1, 1, 32'h8000_0400, 0, 32'h8000_006c);
    reset = 1; stall = 1; csr_redirect = 1; csr_pc = 32'h8000_1000;
    run_cycle();
    check("rst_noflush", 32'(obs_flush), 0);
    csr_redirect = 0;
    run_cycle();
    check("rst_pc", pc, RV);
    reset = 0;
    run_cycle();
    check("rst_stall_next", obs_next, RV);
    stall = 0;
    for (int k = 0; k < 3; k++) begin
      fetch_at(32'h8000_0060 + 32'(4 * k)); run_cycle();
      check("rst_miss_pt", 32'(obs_pt), 0);
      check("rst_miss_ptgt", obs_ptgt, 32'h8000_0064 + 32'(4 * k));
    end

    // random phase
    for (int n = 0; n < 500; n++) begin
      reset        = ($urandom_range(0, 99) < 2);
      stall        = ($urandom_range(0, 99) < 20);
      csr_redirect = ($urandom_range(0, 99) < 5);
      csr_pc       = 32'h8000_0000 + 32'(4 * $urandom_range(0, 63));
      ex_valid     = ($urandom_range(0, 99) < 70);
      ex_pc        = 32'h8000_0000 + 32'(4 * $urandom_range(0, 23)) +
                     (($urandom_range(0, 3) == 0) ? 32'h400 : 32'h0);
      ex_is_branch = ($urandom_range(0, 99) < 75);
      ex_taken     = ex_is_branch ? 1'($urandom_range(0, 1)) : 1'b0;
      ex_target    = 32'h8000_0000 + 32'(4 * $urandom_range(0, 7));
      ex_pred_taken  = 1'($urandom_range(0, 1));
      ex_pred_target = ($urandom_range(0, 1) == 1) ? ex_target : ex_pc + 4;
      run_cycle();
    end
    reset = 0; idle();
    run_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
